// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg: upstream valid/ready/data in, downstream valid/ready/data out.
// The slave view is the register itself; the master view drives it (neighbouring stages or a bench).
interface pipe_skid_reg_if #(
  parameter int unsigned DATA_W = 64
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// in_ready depends only on local state, freeze and flush, never on out_ready or in_valid.
module pipe_skid_reg #(
  parameter int unsigned       DATA_W  = 64,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  freeze,
  pipe_skid_reg_if.slave        bus,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  logic main_v;
  logic skid_v;
  logic push;
  logic pop;

  assign main_v = (state_q != EMPTY);
  assign skid_v = (state_q == FULL);

  assign bus.in_ready  = ~skid_v & ~freeze & ~flush;
  assign bus.out_valid = main_v & ~freeze & ~flush;
  assign bus.out_data  = main_q;
  assign occupancy     = state_q;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Freeze needs no branch: it already forces push and pop low.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RST_VAL;
      skid_d  = RST_VAL;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_d  = bus.in_data;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_d = FULL;
            skid_d  = bus.in_data;
          end else if (push && pop) begin
            main_d  = bus.in_data;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg (DATA_W=32, RST_VAL=0): directed scenarios plus randomized traffic
// compared against a FIFO-queue reference model of the buffered entries.
module tb_pipe_skid_reg;

  localparam int unsigned W = 32;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       freeze;
  logic [1:0] occupancy;

  int total;
  int bad;

  // Reference model: buffered entries in arrival order, plus the last value that left.
  logic [W-1:0] mq[$];
  logic [W-1:0] last_out;

  pipe_skid_reg_if #(.DATA_W(W)) bus ();

  pipe_skid_reg #(
    .DATA_W (W),
    .RST_VAL(32'h0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .freeze   (freeze),
    .bus      (bus),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_occ();
    return mq.size();
  endfunction

  function automatic logic [W-1:0] exp_out();
    if (mq.size() > 0) return mq[0];
    return last_out;
  endfunction

  function automatic logic exp_in_ready();
    return (mq.size() < 2) && !freeze && !flush;
  endfunction

  function automatic logic exp_out_valid();
    return (mq.size() > 0) && !freeze && !flush;
  endfunction

  task automatic model_reset();
    mq.delete();
    last_out = '0;
  endtask

  // Applies the transfer rules for the inputs held across the current rising edge.
  task automatic model_edge();
    logic do_push;
    logic do_pop;
    if (rst || flush) begin
      model_reset();
    end else begin
      do_push = bus.in_valid && exp_in_ready();
      do_pop  = bus.out_ready && exp_out_valid();
      if (do_pop) last_out = mq.pop_front();
      if (do_push) mq.push_back(bus.in_data);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy,
                       input logic frz, input logic fl);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    freeze        = frz;
    flush         = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cycle(input logic v, input logic [W-1:0] d, input logic ordy,
                       input logic frz, input logic fl);
    drive(v, d, ordy, frz, fl);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    total++;
    if (bus.out_data !== 32'h0) begin
      bad++; $display("FAIL reset_out_data: got %h want 00000000", bus.out_data);
    end
    total++;
    if (occupancy !== 2'd0) begin
      bad++; $display("FAIL reset_occupancy: got %0d want 0", occupancy);
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, vals[i], 1'b1, 1'b0, 1'b0);
      total++;
      if (bus.out_data !== vals[i]) begin
        bad++; $display("FAIL stream_data[%0d]: got %h want %h", i, bus.out_data, vals[i]);
      end
      total++;
      if (occupancy !== 2'd1 || bus.in_ready !== 1'b1) begin
        bad++; $display("FAIL stream_occ_ready[%0d]: got occ=%0d rdy=%b want occ=1 rdy=1",
                        i, occupancy, bus.in_ready);
      end
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    total++;
    if (occupancy !== 2'd0 || bus.out_data !== 32'h33) begin
      bad++; $display("FAIL stream_drain: got occ=%0d data=%h want occ=0 data=00000033",
                      occupancy, bus.out_data);
    end
  endtask

  task automatic test_skid();
    cycle(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hA2, 1'b0, 1'b0, 1'b0);
    total++;
    if (occupancy !== 2'd2 || bus.in_ready !== 1'b0 || bus.out_data !== 32'hA1) begin
      bad++; $display("FAIL skid_full: got occ=%0d rdy=%b data=%h want occ=2 rdy=0 data=000000a1",
                      occupancy, bus.in_ready, bus.out_data);
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    total++;
    if (occupancy !== 2'd1 || bus.in_ready !== 1'b1 || bus.out_data !== 32'hA2) begin
      bad++; $display("FAIL skid_drain1: got occ=%0d rdy=%b data=%h want occ=1 rdy=1 data=000000a2",
                      occupancy, bus.in_ready, bus.out_data);
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    total++;
    if (occupancy !== 2'd0 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL skid_drain0: got occ=%0d vld=%b want occ=0 vld=0",
                      occupancy, bus.out_valid);
    end
  endtask

  task automatic test_freeze();
    cycle(1'b1, 32'hB1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hB2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'hEE, 1'b1, 1'b1, 1'b0);
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || occupancy !== 2'd2) begin
        bad++; $display("FAIL freeze_hold[%0d]: got vld=%b rdy=%b occ=%0d want vld=0 rdy=0 occ=2",
                        i, bus.out_valid, bus.in_ready, occupancy);
      end
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hB1) begin
      bad++; $display("FAIL freeze_first: got vld=%b data=%h want vld=1 data=000000b1",
                      bus.out_valid, bus.out_data);
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hB2 || occupancy !== 2'd1) begin
      bad++; $display("FAIL freeze_second: got vld=%b data=%h occ=%0d want vld=1 data=000000b2 occ=1",
                      bus.out_valid, bus.out_data, occupancy);
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    cycle(1'b1, 32'hC1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hC2, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hCC, 1'b1, 1'b1, 1'b1);
    total++;
    if (occupancy !== 2'd0 || bus.out_data !== 32'h0 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL flush_clear: got occ=%0d data=%h vld=%b want occ=0 data=00000000 vld=0",
                      occupancy, bus.out_data, bus.out_valid);
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    total++;
    if (occupancy !== 2'd0 || bus.out_data === 32'hCC || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL flush_drop: got occ=%0d data=%h vld=%b want occ=0 data=00000000 vld=0",
                      occupancy, bus.out_data, bus.out_valid);
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 32'hD1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hD2, 1'b0, 1'b0, 1'b0);
    total++;
    if (occupancy !== 2'd2) begin
      bad++; $display("FAIL areset_pre: got occ=%0d want 2", occupancy);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (occupancy !== 2'd0 || bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 ||
        bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL areset_now: got occ=%0d vld=%b data=%h rdy=%b want occ=0 vld=0 data=00000000 rdy=1",
                      occupancy, bus.out_valid, bus.out_data, bus.in_ready);
    end
    tick();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 32'hDD, 1'b0, 1'b0, 1'b0);
    total++;
    if (bus.out_data !== 32'hDD || occupancy !== 2'd1 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL areset_after: got data=%h occ=%0d vld=%b want data=000000dd occ=1 vld=1",
                      bus.out_data, occupancy, bus.out_valid);
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic v, ordy, frz, fl;
    logic [W-1:0] d;
    for (int i = 0; i < 400; i++) begin
      v    = ($urandom_range(0, 99) < 70);
      ordy = ($urandom_range(0, 99) < 60);
      frz  = ($urandom_range(0, 99) < 10);
      fl   = ($urandom_range(0, 99) < 4);
      d    = $urandom;
      cycle(v, d, ordy, frz, fl);
      total++;
      if (occupancy !== 2'(exp_occ()) || bus.out_data !== exp_out() ||
          bus.in_ready !== exp_in_ready() || bus.out_valid !== exp_out_valid()) begin
        bad++;
        $display("FAIL random[%0d]: got occ=%0d data=%h rdy=%b vld=%b want occ=%0d data=%h rdy=%b vld=%b",
                 i, occupancy, bus.out_data, bus.in_ready, bus.out_valid,
                 exp_occ(), exp_out(), exp_in_ready(), exp_out_valid());
      end
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    flush         = 1'b0;
    freeze        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    model_reset();

    test_reset();
    test_stream();
    test_skid();
    test_freeze();
    test_flush();
    test_async_reset();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised inter-stage pipeline register; next generation of the fixed 2×32-bit stage latch.
- Adds a valid/ready handshake on both sides and a 2-entry skid buffer, so in_ready never depends combinationally on out_ready.
- Keeps the freeze and flush semantics of the existing stage registers.
- Sits between any two pipeline stages (IF/ID, ID/EX, ...); payload packing (pc, instruction, control) is done by the instantiating stage.

Parameters:
- DATA_W, 64, payload width in bits (e.g. pc and instruction = 64).
- RST_VAL, 0 (DATA_W bits), value loaded into both data registers on reset and on flush.

Ports:
- clk        input   1       clock, rising edge
- rst        input   1       asynchronous, active-high reset
- flush      input   1       synchronous kill of all buffered entries
- freeze     input   1       hazard stall; blocks transfers on both sides
- in_valid   input   1       upstream has data
- in_data    input   DATA_W  upstream payload
- in_ready   output  1       block can accept in_data this cycle
- out_valid  output  1       out_data holds a valid entry
- out_data   output  DATA_W  downstream payload (the main register)
- out_ready  input   1       downstream accepts this cycle
- occupancy  output  2       number of valid entries: 0, 1 or 2

Behaviour:
- Storage: main register (main_data, main_v) and skid register (skid_data, skid_v).
- State is encoded by occupancy:
  - EMPTY (0): main_v=0, skid_v=0.
  - ONE (1): main_v=1, skid_v=0.
  - FULL (2): main_v=1, skid_v=1.
  - skid_v=1 with main_v=0 is illegal and unreachable.
- Combinational outputs:
  - in_ready = ~skid_v & ~freeze & ~flush.
  - out_valid = main_v & ~freeze & ~flush.
  - out_data = main_data at all times, including when invalid.
  - in_ready must not depend on out_ready or in_valid.
- Handshake events:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - A transfer happens only on the rising clk edge with both signals high.
- Transitions, priority order:
  - rst asynchronously forces EMPTY; main_data = skid_data = RST_VAL.
  - flush (synchronous, overrides freeze and all handshakes): next state EMPTY, both data regs = RST_VAL; same-cycle in_data is dropped and nothing is popped.
  - freeze (no flush): hold all state. This follows from in_ready=0 and out_valid=0.
  - EMPTY: push -> ONE, main_data <= in_data.
  - ONE: push & ~pop -> FULL, skid_data <= in_data.
  - ONE: push & pop -> ONE, main_data <= in_data.
  - ONE: pop & ~push -> EMPTY, main_data holds its stale value.
  - FULL: in_ready=0; pop -> ONE, main_data <= skid_data, skid_data holds; no pop -> hold.
- Latency and throughput:
  - Input to output is 1 cycle: data pushed at edge N appears on out_data after edge N.
  - Sustained throughput is 1 entry per cycle while out_ready=1.
  - One cycle of out_ready=0 fills the skid; the next accepted cycle drains it while in_ready is low.
- Ordering: entries leave strictly in arrival order; no entry is duplicated or lost except by flush.
- Reset mid-operation: buffered data is discarded and outputs go to reset values immediately, not at the clock edge.
- Outputs after reset: in_ready=1 (if freeze=0 and flush=0), out_valid=0, out_data=RST_VAL, occupancy=0.

Test Plan (DATA_W=32, RST_VAL=0):
1. Assert rst for 2 cycles, then release with in_valid=0 -> out_valid=0, out_data=0x0, occupancy=0, in_ready=1.
2. Stream 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1 -> out_data shows 0x11, 0x22, 0x33 one cycle after each push; occupancy stays 1; in_ready stays 1.
3. Push 0xA1, then 0xA2 with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA1. Raise out_ready -> next cycle out_data=0xA2, occupancy=1, in_ready=1, then drains to 0.
4. FULL with 0xB1/0xB2, assert freeze for 3 cycles with out_ready=1 -> out_valid=0, in_ready=0, occupancy stays 2. After releasing freeze, 0xB1 then 0xB2 are delivered in order.
5. FULL, assert flush together with in_valid=1 (in_data=0xCC), freeze=1, out_ready=1 -> next cycle occupancy=0, out_data=0x0; 0xCC is never output.
6. Assert rst asynchronously between clock edges while occupancy=2 -> outputs reset immediately. After release, the next push of 0xDD appears on out_data one cycle later.
